// File: rtl/score_bcd_scheduler.sv
// score_bcd_scheduler
//
// Double-dabble (shift-add-3) binary-to-BCD converter with one engine
// shared round-robin between two requesters: port 0 is the current score and
// port 1 is the high score. Each port keeps its last result in its own
// register, so the display sees stable digits between conversions.
//
// Optional build macro: BCD_SATURATE_EN. When it is defined, an overflowing
// result is written as all nines. When it is not defined, the result is
// value mod 10^DIGITS. The overflow flag is set in both builds, and timing
// is the same in both builds.
//
// Parameters:
//   WIDTH   binary operand width in bits (>= 2)
//   DIGITS  BCD digits produced per result (>= 1)
//
// Ports:
//   clk_i             rising-edge clock
//   rst_ni            asynchronous active-low reset
//   req0_i / req1_i   level request; the requester holds it until its ack
//   value0_i/value1_i binary operand; sampled once, in the LOAD state
//   ack0_o / ack1_o   one-cycle pulse marking the cycle bcd/ovf update
//   bcd0_o / bcd1_o   packed BCD result; digit k sits at bits [4k+3:4k]
//   ovf0_o / ovf1_o   set when the value exceeded 10^DIGITS-1
//   busy_o            high while the engine is not idle
module score_bcd_scheduler #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req0_i,
  input  logic [WIDTH-1:0]      value0_i,
  output logic                  ack0_o,
  output logic [4*DIGITS-1:0]   bcd0_o,
  output logic                  ovf0_o,
  input  logic                  req1_i,
  input  logic [WIDTH-1:0]      value1_i,
  output logic                  ack1_o,
  output logic [4*DIGITS-1:0]   bcd1_o,
  output logic                  ovf1_o,
  output logic                  busy_o
);

  localparam int unsigned BcdW = 4 * DIGITS;
  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;

  state_e            state_q;
  logic              grant_q;     // 0: port 0, 1: port 1
  logic              grant_d;
  logic              rr_last_q;
  logic [CntW-1:0]   cnt_q;
  logic [WIDTH-1:0]  op_q;
  logic [BcdW-1:0]   acc_q;
  logic              ovf_acc_q;
  logic [BcdW-1:0]   bcd0_q, bcd1_q;
  logic              ovf0_q, ovf1_q;
  logic              ack0_q, ack1_q;

  // Datapath for one shift step, and the value written back at DONE.
  logic [BcdW-1:0]   acc_adj;
  logic [BcdW-1:0]   acc_shift;
  logic [WIDTH-1:0]  op_shift;
  logic              shift_out;
  logic [BcdW-1:0]   res_bcd;

  // Arbitration: a lone requester wins. On a tie the port that was not
  // served last wins.
  always_comb begin
    grant_d = 1'b0;
    if (req0_i && req1_i) begin
      grant_d = ~rr_last_q;
    end else if (req1_i) begin
      grant_d = 1'b1;
    end
  end

  // Add 3 to each digit that is >= 5 before the shift. Digits do not carry
  // into each other. A 1 that leaves the top digit means the value has
  // overflowed DIGITS digits.
  always_comb begin
    acc_adj = acc_q;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (acc_q[4*k +: 4] >= 4'd5) begin
        acc_adj[4*k +: 4] = acc_q[4*k +: 4] + 4'd3;
      end
    end
    {shift_out, acc_shift, op_shift} = {acc_adj, op_q, 1'b0};
  end

  always_comb begin
    res_bcd = acc_q;
`ifdef BCD_SATURATE_EN
    if (ovf_acc_q) begin
      for (int k = 0; k < int'(DIGITS); k++) begin
        res_bcd[4*k +: 4] = 4'd9;
      end
    end
`else
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      grant_q   <= 1'b0;
      rr_last_q <= 1'b1;
      cnt_q     <= '0;
      op_q      <= '0;
      acc_q     <= '0;
      ovf_acc_q <= 1'b0;
      bcd0_q    <= '0;
      bcd1_q    <= '0;
      ovf0_q    <= 1'b0;
      ovf1_q    <= 1'b0;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req0_i || req1_i) begin
            grant_q <= grant_d;
            state_q <= StLoad;
          end
        end
        StLoad: begin
          op_q      <= grant_q ? value1_i : value0_i;
          acc_q     <= '0;
          ovf_acc_q <= 1'b0;
          cnt_q     <= CntW'(WIDTH - 1);
          state_q   <= StShift;
        end
        StShift: begin
          acc_q     <= acc_shift;
          op_q      <= op_shift;
          ovf_acc_q <= ovf_acc_q | shift_out;
          if (cnt_q == '0) begin
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StDone: begin
          if (grant_q) begin
            bcd1_q <= res_bcd;
            ovf1_q <= ovf_acc_q;
            ack1_q <= 1'b1;
          end else begin
            bcd0_q <= res_bcd;
            ovf0_q <= ovf_acc_q;
            ack0_q <= 1'b1;
          end
          rr_last_q <= grant_q;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ack0_o = ack0_q;
  assign bcd0_o = bcd0_q;
  assign ovf0_o = ovf0_q;
  assign ack1_o = ack1_q;
  assign bcd1_o = bcd1_q;
  assign ovf1_o = ovf1_q;
  assign busy_o = (state_q != StIdle);

endmodule

// File: tb/tb_score_bcd_scheduler.sv
// Bench for score_bcd_scheduler.
// dut    uses WIDTH=8, DIGITS=3.
// dut_b  uses WIDTH=8, DIGITS=2, so the overflow path gets exercised.
// Expected results are pushed into per-port queues when a request is driven.
// They are popped and compared when the matching ack pulses.
module tb_score_bcd_scheduler;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       req0 = 1'b0, req1 = 1'b0;
  logic [7:0] value0 = '0, value1 = '0;
  logic       ack0, ack1, ovf0, ovf1, busy;
  logic [11:0] bcd0, bcd1;

  logic       b_req = 1'b0;
  logic [7:0] b_value = '0;
  logic       b_ack, b_ovf, b_ack1, b_ovf1, b_busy;
  logic [7:0] b_bcd, b_bcd1;

  score_bcd_scheduler #(.WIDTH(8), .DIGITS(3)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req0_i(req0), .value0_i(value0), .ack0_o(ack0), .bcd0_o(bcd0), .ovf0_o(ovf0),
    .req1_i(req1), .value1_i(value1), .ack1_o(ack1), .bcd1_o(bcd1), .ovf1_o(ovf1),
    .busy_o(busy)
  );

  score_bcd_scheduler #(.WIDTH(8), .DIGITS(2)) dut_b (
    .clk_i(clk), .rst_ni(rst_n),
    .req0_i(b_req), .value0_i(b_value), .ack0_o(b_ack), .bcd0_o(b_bcd), .ovf0_o(b_ovf),
    .req1_i(1'b0), .value1_i(8'd0), .ack1_o(b_ack1), .bcd1_o(b_bcd1), .ovf1_o(b_ovf1),
    .busy_o(b_busy)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [16:0] q0[$], q1[$], qb[$];  // {ovf, bcd[15:0]}
  logic [12:0] last0 = '0, last1 = '0;
  logic [8:0]  lastb = '0;
  int ack_port[$];
  int ack_cyc[$];
  logic [16:0] e0, e1, eb;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference conversion: value mod 10^d in packed BCD. Saturates in the
  // BCD_SATURATE_EN build.
  function automatic logic [16:0] model(input int v, input int d);
    int lim;
    int m;
    logic [15:0] b;
    logic o;
    lim = 1;
    b = '0;
    for (int i = 0; i < d; i++) lim *= 10;
    o = (v >= lim);
    m = v % lim;
    for (int i = 0; i < d; i++) begin
      b[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
`ifdef BCD_SATURATE_EN
    if (o) for (int i = 0; i < d; i++) b[4*i +: 4] = 4'd9;
`endif
    return {o, b};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n) begin
      check_eq("ack_excl", {31'b0, ack0 & ack1}, 32'd0);
      if (ack0) begin
        ack_port.push_back(0);
        ack_cyc.push_back(cyc);
        if (q0.size() == 0) check_eq("ack0_unexpected", {31'b0, ack0}, 32'd0);
        else begin
          e0 = q0.pop_front();
          check_eq("bcd0", {20'b0, bcd0}, {20'b0, e0[11:0]});
          check_eq("ovf0", {31'b0, ovf0}, {31'b0, e0[16]});
          last0 = {e0[16], e0[11:0]};
        end
      end else check_eq("hold0", {19'b0, ovf0, bcd0}, {19'b0, last0});
      if (ack1) begin
        ack_port.push_back(1);
        ack_cyc.push_back(cyc);
        if (q1.size() == 0) check_eq("ack1_unexpected", {31'b0, ack1}, 32'd0);
        else begin
          e1 = q1.pop_front();
          check_eq("bcd1", {20'b0, bcd1}, {20'b0, e1[11:0]});
          check_eq("ovf1", {31'b0, ovf1}, {31'b0, e1[16]});
          last1 = {e1[16], e1[11:0]};
        end
      end else check_eq("hold1", {19'b0, ovf1, bcd1}, {19'b0, last1});
      if (b_ack) begin
        if (qb.size() == 0) check_eq("ackb_unexpected", {31'b0, b_ack}, 32'd0);
        else begin
          eb = qb.pop_front();
          check_eq("bcd_d2", {24'b0, b_bcd}, {24'b0, eb[7:0]});
          check_eq("ovf_d2", {31'b0, b_ovf}, {31'b0, eb[16]});
          lastb = {eb[16], eb[7:0]};
        end
      end else check_eq("hold_d2", {23'b0, b_ovf, b_bcd}, {23'b0, lastb});
    end
  end

  task automatic check_zero(input string tag);
    check_eq({tag, "_bcd0"}, {20'b0, bcd0}, 32'd0);
    check_eq({tag, "_bcd1"}, {20'b0, bcd1}, 32'd0);
    check_eq({tag, "_flags"}, {26'b0, ovf0, ovf1, ack0, ack1, busy, b_ack}, 32'd0);
    check_eq({tag, "_bcd_d2"}, {24'b0, b_bcd}, 32'd0);
  endtask

  task automatic clear_model();
    q0.delete(); q1.delete(); qb.delete();
    ack_port.delete(); ack_cyc.delete();
    last0 = '0; last1 = '0; lastb = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero("reset");
    repeat (2) @(negedge clk);
    clear_model();
    rst_n = 1'b1;
  endtask

  // Drive one request on dut, wait (bounded) for its ack, then drop the request.
  // lat is measured in clock edges from driving req to seeing the ack.
  task automatic run_req(input int p, input logic [7:0] v, output int lat);
    int t;
    int start;
    start = cyc;
    if (p == 0) begin value0 = v; q0.push_back(model(int'(v), 3)); req0 = 1'b1; end
    else begin value1 = v; q1.push_back(model(int'(v), 3)); req1 = 1'b1; end
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(p == 0 ? ack0 : ack1) && t < 60);
    check_eq("ack_seen", {31'b0, (p == 0 ? ack0 : ack1)}, 32'd1);
    lat = cyc - start;
    if (p == 0) req0 = 1'b0; else req1 = 1'b0;
  endtask

  task automatic run_req_b(input logic [7:0] v);
    int t;
    b_value = v;
    qb.push_back(model(int'(v), 2));
    b_req = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!b_ack && t < 60);
    check_eq("ack_d2_seen", {31'b0, b_ack}, 32'd1);
    b_req = 1'b0;
  endtask

  initial begin
    int lat, lat1, t, n1;
    logic [7:0] pat0 [4];
    logic [7:0] pat1 [4];
    logic [7:0] patb [5];
    pat0 = '{8'd0, 8'd9, 8'd10, 8'd128};
    pat1 = '{8'd1, 8'd99, 8'd150, 8'd254};
    patb = '{8'd255, 8'd0, 8'd99, 8'd100, 8'd45};

    #1;
    check_zero("por");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single conversion, checking latency and that the other port is untouched
    @(negedge clk);
    run_req(0, 8'd255, lat);
    check_eq("latency", lat, 32'd11);
    check_eq("bcd1_untouched", {20'b0, bcd1}, 32'd0);

    // Simultaneous requests right after reset: port 0 is served first
    do_reset();
    @(negedge clk);
    fork
      run_req(0, 8'd42, lat);
      run_req(1, 8'd7, lat1);
    join
    @(negedge clk);
    check_eq("tie_lat0", lat, 32'd11);
    check_eq("tie_lat1", lat1, 32'd22);
    check_eq("tie_n", ack_port.size(), 32'd2);
    if (ack_port.size() == 2) begin
      check_eq("tie_first", ack_port[0], 32'd0);
      check_eq("tie_second", ack_port[1], 32'd1);
    end

    // Both requests held: acks alternate 0,1,0,1 and are 11 cycles apart
    ack_port.delete(); ack_cyc.delete();
    value0 = 8'd100; value1 = 8'd199;
    for (int i = 0; i < 2; i++) begin
      q0.push_back(model(100, 3));
      q1.push_back(model(199, 3));
    end
    req0 = 1'b1; req1 = 1'b1;
    t = 0; n1 = 0;
    while (n1 < 2 && t < 100) begin
      @(negedge clk);
      t++;
      if (ack1) n1++;
    end
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    check_eq("alt_n", ack_port.size(), 32'd4);
    if (ack_port.size() == 4) begin
      for (int i = 0; i < 4; i++) check_eq("alt_order", ack_port[i], i % 2);
      for (int i = 0; i < 3; i++) check_eq("alt_space", ack_cyc[i+1] - ack_cyc[i], 32'd11);
    end

    // The operand is captured at LOAD, so a later change has no effect
    fork
      run_req(0, 8'd12, lat);
      begin
        repeat (4) @(negedge clk);
        value0 = 8'd99;
      end
    join
    run_req(0, 8'd99, lat);

    // A few more patterns on each port
    for (int i = 0; i < 4; i++) begin
      run_req(0, pat0[i], lat);
      run_req(1, pat1[i], lat);
    end

    // DIGITS=2 instance, covering overflow and zero
    for (int i = 0; i < 5; i++) run_req_b(patb[i]);

    // Reset in the middle of SHIFT: outputs clear at once and no ack is issued
    @(negedge clk);
    value0 = 8'd200; req0 = 1'b1;
    repeat (5) @(negedge clk);
    check_eq("busy_shift", {31'b0, busy}, 32'd1);
    value1 = 8'd33; req1 = 1'b1;
    rst_n = 1'b0;
    #1;
    check_zero("midreset");
    repeat (2) @(negedge clk);
    check_zero("inreset");
    clear_model();
    q0.push_back(model(200, 3));
    q1.push_back(model(33, 3));
    rst_n = 1'b1;
    t = 0;
    while (t < 60 && (req0 || req1)) begin
      @(negedge clk);
      t++;
      if (ack0) req0 = 1'b0;
      if (ack1) req1 = 1'b0;
    end
    @(negedge clk);
    check_eq("post_rst_n", ack_port.size(), 32'd2);
    if (ack_port.size() == 2) check_eq("post_rst_first", ack_port[0], 32'd0);

    repeat (3) @(negedge clk);
    check_eq("q0_drained", q0.size(), 32'd0);
    check_eq("q1_drained", q1.size(), 32'd0);
    check_eq("qb_drained", qb.size(), 32'd0);
    check_eq("idle_end", {31'b0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/score_bcd_scheduler.md
Name: score_bcd_scheduler

Overview:
- Sequential shift-add-3 (double-dabble) binary-to-BCD engine shared between two requesters: current score (port 0) and high score (port 1).
- Round-robin arbitration between the two requesters, one engine, one conversion at a time.
- Sits between the game-logic score registers and the seven-segment display drivers.
- Results are held in per-requester registers, so the display sees stable digits between conversions.

Parameters:
- WIDTH, 8, binary operand width in bits (≥2).
- DIGITS, 3, number of BCD digits produced per result (≥1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0  in  1  requester 0 conversion request, level; held until ack0.
- value0  in  WIDTH  requester 0 binary operand.
- ack0  out  1  one-cycle pulse: bcd0/ovf0 updated this cycle.
- bcd0  out  4*DIGITS  requester 0 result; digit k at bits [4k+3:4k], k=0 is ones.
- ovf0  out  1  requester 0 result exceeded 10^DIGITS-1.
- req1, value1, ack1, bcd1, ovf1: same as above, for requester 1.
- busy  out  1  high while the engine is not IDLE.

Behaviour:
- Reset (async, rst_n low): state=IDLE; bcd0=bcd1=0; ovf0=ovf1=0; ack0=ack1=0; busy=0; rr_last=1, so requester 0 wins the first tie.
- Reset mid-conversion aborts it; no ack is issued; result registers are cleared.
- States: IDLE, LOAD, SHIFT, DONE.
  - IDLE: if any req is high, grant per round-robin and go to LOAD. If only one requester is requesting, it wins. If both are requesting, grant the one ≠ rr_last.
  - LOAD: capture value of the granted port into the shift register; clear the digit accumulator and ovf_acc; cnt=WIDTH-1; go to SHIFT. Later value changes are ignored for this conversion.
  - SHIFT, one bit per cycle:
    - Every digit ≥5 gets +3 (4-bit add, no carry between digits).
    - Shift {digits, operand} left by 1.
    - The bit shifted out of the top digit ORs into ovf_acc.
    - When cnt==0, go to DONE; otherwise cnt-=1.
  - DONE: write the accumulator into the granted port's bcd register and ovf_acc into its ovf; pulse ack for exactly this cycle; rr_last=granted; go to IDLE.
- Latency: req sampled high in IDLE at edge N → ack high during the cycle after edge N+WIDTH+2. With WIDTH=8, ack is asserted 11 cycles after grant.
- Throughput: one conversion per WIDTH+3 cycles. A requester holding req high through ack is converted again, alternating with the other port if both are requesting.
- Requester rules:
  - A requester drops req in the cycle after ack (or keeps it high for a back-to-back conversion).
  - A req dropped before ack does not cancel a granted conversion; the result is still written and ack still pulses.
- Non-granted port outputs hold their previous values. ack0 and ack1 are never high simultaneously.
- Arithmetic: without saturation the result equals value mod 10^DIGITS, in packed BCD. Each digit is always 0–9.
- busy = (state != IDLE).

Optional Feature:
- Macro: BCD_SATURATE_EN.
- Defined: when ovf_acc=1 at DONE, the bcd register is written as all digits 9 (e.g. 0x99 for DIGITS=2); ovf is still set.
- Undefined: the bcd register is written with the truncated result (value mod 10^DIGITS); ovf is set.
- Timing is identical in both builds.

Test Plan:
- WIDTH=8, DIGITS=3; req0=1, value0=255 → ack0 pulses 11 cycles after grant; bcd0=0x255; ovf0=0; bcd1 unchanged (0x000).
- req0 and req1 rise in the same cycle from reset, value0=42, value1=7 → ack0 first (bcd0=0x042), then ack1 one conversion later (bcd1=0x007). No overlap of ack0/ack1.
- Both req held high continuously, value0=100, value1=199 → acks alternate 0,1,0,1, spaced 11 cycles apart; bcd0=0x100, bcd1=0x199.
- Change value0 from 12 to 99 three cycles after grant → bcd0=0x012; a second request then yields 0x099.
- DIGITS=2, value0=255 → macro undefined: bcd0=0x55, ovf0=1. Macro defined: bcd0=0x99, ovf0=1. value0=0 → bcd0=0x00, ovf0=0.
- Assert rst_n low mid-SHIFT → all outputs 0 immediately and no ack. After release, a pending req1 and req0 are served requester 0 first.
